ex_stage: RTL

- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID/EX pipeline register outputs and produces the ALU result, destination register number and store data for the EX/MEM register.
- Owns the HI/LO registers and an iterative 32-cycle unsigned multiplier for MULTU.
- Raises a stall to the hazard unit while a multiply is in flight.

---
 rtl/ex_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, HI/LO and a WIDTH-cycle shift-add multiplier.
// Define EX_SIGNED_MULT_EN to also accept signed MULT (func 011000).
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       EX_EX,
    input  logic [5:0]       func_EX,
    input  logic [WIDTH-1:0] RD1_EX,
    input  logic [WIDTH-1:0] RD2_EX,
    input  logic [WIDTH-1:0] imm_EX,
    input  logic [4:0]       RT_EX,
    input  logic [4:0]       RD_EX,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [4:0]       write_reg,
    output logic [WIDTH-1:0] store_data,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, step;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   a, b, a_mag, b_mag, res;
    logic               mul_op, mul_neg;

    assign a = RD1_EX;
    assign b = EX_EX[0] ? imm_EX : RD2_EX;

`ifdef EX_SIGNED_MULT_EN
    logic smul;
    assign smul    = EX_EX[2:1] == 2'b10 && func_EX == 6'b011000;
    assign mul_op  = (EX_EX[2:1] == 2'b10 && func_EX == 6'b011001) || smul;
    assign a_mag   = (smul && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (smul && b[WIDTH-1]) ? -b : b;
    assign mul_neg = smul && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
    assign mul_op  = EX_EX[2:1] == 2'b10 && func_EX == 6'b011001;
    assign a_mag   = a;
    assign b_mag   = b;
    assign mul_neg = 1'b0;
`endif

    always_comb begin
        res = '0;
        if (EX_EX[2:1] == 2'b00) res = a + b;
        else if (EX_EX[2:1] == 2'b01) res = a - b;
        else if (EX_EX[2:1] == 2'b10) begin
            case (func_EX)
                6'b100000: res = a + b;
                6'b100010: res = a - b;
                6'b100100: res = a & b;
                6'b100101: res = a | b;
                6'b101010: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                6'b010000: res = hi_q;
                6'b010010: res = lo_q;
                default:   res = '0;
            endcase
        end
    end

    assign alu_result = res;
    assign zero       = res == '0;
    assign write_reg  = EX_EX[3] ? RD_EX : RT_EX;
    assign store_data = RD2_EX;
    assign stall      = (state_q == IDLE && mul_op) || state_q == BUSY;
    assign hi         = hi_q;
    assign lo         = lo_q;

    // One shift-add step: conditional add into the upper half, then shift right with carry.
    assign sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign step = {sum, prod_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (mul_op) begin
                mcand_d = a_mag;
                prod_d  = {{WIDTH{1'b0}}, b_mag};
                cnt_d   = CW'(WIDTH);
                neg_d   = mul_neg;
                state_d = BUSY;
            end
            BUSY: begin
                prod_d = step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    {hi_d, lo_d} = neg_q ? -step : step;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule
